// File: rtl/btb_pkg.sv
// Shared BTB types: entry layout, 2-bit counter encodings and the tag helper.
package btb_pkg;

  // Widest tag: ENTRIES >= 4 leaves at most pc[31:4].
  localparam int TAG_W = 28;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_e             ctr;
  } btb_entry_t;

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
    logic [31:0] shifted;
    shifted = pc >> (idx_w + 2);
    return shifted[TAG_W-1:0];
  endfunction

endpackage

// File: rtl/if_fetch_predictor_sat_counter2.sv
// Two-bit saturating counter step: count up on taken, down on not taken.
module sat_counter2
  import btb_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i && (ctr_i != ST)) begin
      ctr_o = ctr_i + 2'd1;
    end else if (!inc_i && (ctr_i != SNT)) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/if_fetch_predictor.sv
// Fetch PC register with a direct-mapped BTB and 2-bit counters.
// Define BTB_BYPASS_EN to forward a same-cycle training write into the lookup.
module if_fetch_predictor
  import btb_pkg::*;
#(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        modify_pc_ex,
  input  logic [31:0] update_pc_ex,
  input  logic        update_btb_ex,
  input  logic [31:0] pc_ex,
  input  logic        ex_branch_taken,
  input  logic [31:0] jump_addr_ex,
  input  logic        ex_is_jump,
  output logic [31:0] pc_if,
  output logic        predictedTaken_if,
  output logic [31:0] predicted_target_if
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t  btb_q [ENTRIES];
  btb_entry_t  btb_d [ENTRIES];
  logic [31:0] pc_if_q, pc_if_d;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  btb_entry_t       rd_entry, ex_entry, wr_entry;
  logic             rd_hit, ex_hit, wr_en;
  logic [1:0]       ctr_next;

  assign rd_idx = pc_if_q[IDX_W+1:2];
  assign rd_tag = pc_tag(pc_if_q, IDX_W);
  assign wr_idx = pc_ex[IDX_W+1:2];
  assign wr_tag = pc_tag(pc_ex, IDX_W);

  assign ex_entry = btb_q[wr_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == wr_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_i (ex_entry.ctr),
    .inc_i (ex_branch_taken),
    .ctr_o (ctr_next)
  );

  // Training: jumps always install strongly taken; branches train on hit,
  // allocate weakly taken on a taken miss, and leave a not-taken miss alone.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = ex_entry;
    if (update_btb_ex) begin
      if (ex_is_jump) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: wr_tag, target: jump_addr_ex, ctr: ST};
      end else if (ex_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_e'(ctr_next);
        if (ex_branch_taken) wr_entry.target = jump_addr_ex;
      end else if (ex_branch_taken) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: wr_tag, target: jump_addr_ex, ctr: WT};
      end
    end
  end

  always_comb begin
    btb_d = btb_q;
    if (wr_en) btb_d[wr_idx] = wr_entry;
  end

  always_comb begin
`ifdef BTB_BYPASS_EN
    rd_entry = (wr_en && (wr_idx == rd_idx)) ? wr_entry : btb_q[rd_idx];
`else
    rd_entry = btb_q[rd_idx];
`endif
  end

  assign rd_hit              = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign predictedTaken_if   = rd_hit && rd_entry.ctr[1];
  assign predicted_target_if = predictedTaken_if ? rd_entry.target : pc_if_q + 32'd4;
  assign pc_if               = pc_if_q;

  always_comb begin
    pc_if_d = predicted_target_if;
    if (modify_pc_ex)  pc_if_d = update_pc_ex;
    else if (stall_if) pc_if_d = pc_if_q;
  end

  // NOTE: only valid and ctr are reset; tag/target are gated by valid, so
  // leaving them unreset keeps the table a plain RAM-style array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_if_q <= RESET_PC;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
        btb_q[i].ctr   <= SNT;
      end
    end else begin
      pc_if_q <= pc_if_d;
      btb_q   <= btb_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_predictor.sv
// Self-checking bench for if_fetch_predictor: directed vector table plus random model check.
module tb_if_fetch_predictor;

  logic        clk = 1'b0;
  logic        rst_n, stall_if, modify_pc_ex, update_btb_ex, ex_branch_taken, ex_is_jump;
  logic [31:0] update_pc_ex, pc_ex, jump_addr_ex;
  logic [31:0] pc_if, predicted_target_if;
  logic        predictedTaken_if;

  always #5 clk = ~clk;

  if_fetch_predictor dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .stall_if            (stall_if),
    .modify_pc_ex        (modify_pc_ex),
    .update_pc_ex        (update_pc_ex),
    .update_btb_ex       (update_btb_ex),
    .pc_ex               (pc_ex),
    .ex_branch_taken     (ex_branch_taken),
    .jump_addr_ex        (jump_addr_ex),
    .ex_is_jump          (ex_is_jump),
    .pc_if               (pc_if),
    .predictedTaken_if   (predictedTaken_if),
    .predicted_target_if (predicted_target_if)
  );

`ifdef BTB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          rst_n, stall, modify;
    logic [31:0] upc;
    bit          upd;
    logic [31:0] pcex;
    bit          taken;
    logic [31:0] jaddr;
    bit          isjump;
    bit          chk;
    logic [31:0] exp_pc;
    bit          exp_tk;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit r, input bit s, input bit m, input logic [31:0] u,
                              input bit ud, input logic [31:0] pe, input bit tk,
                              input logic [31:0] ja, input bit jm, input bit c,
                              input logic [31:0] ep, input bit et, input logic [31:0] eg);
    vec_t v;
    v.rst_n = r;  v.stall = s;  v.modify = m;  v.upc = u;
    v.upd = ud;   v.pcex = pe;  v.taken = tk;  v.jaddr = ja;  v.isjump = jm;
    v.chk = c;    v.exp_pc = ep; v.exp_tk = et; v.exp_tgt = eg;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n           = v.rst_n;
    stall_if        = v.stall;
    modify_pc_ex    = v.modify;
    update_pc_ex    = v.upc;
    update_btb_ex   = v.upd;
    pc_ex           = v.pcex;
    ex_branch_taken = v.taken;
    jump_addr_ex    = v.jaddr;
    ex_is_jump      = v.isjump;
  endtask

  // Reference model: a 16-entry table written straight from the training rules.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
  endtask

  task automatic model_train(input vec_t v, output bit we, output int idx, output bit nv,
                             output logic [31:0] ntag, output logic [31:0] ntgt, output int nctr);
    bit hit;
    idx  = idx_of(v.pcex);
    ntag = v.pcex >> 6;
    hit  = m_valid[idx] && (m_tag[idx] == ntag);
    we   = 1'b0;
    nv   = m_valid[idx];
    ntgt = m_tgt[idx];
    nctr = m_ctr[idx];
    if (v.upd) begin
      if (v.isjump) begin
        we = 1'b1; nv = 1'b1; ntgt = v.jaddr; nctr = 3;
      end else if (hit) begin
        we = 1'b1; nv = 1'b1;
        if (v.taken) begin
          nctr = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          ntgt = v.jaddr;
        end else begin
          nctr = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (v.taken) begin
        we = 1'b1; nv = 1'b1; ntgt = v.jaddr; nctr = 2;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    vec_t        v;
    bit          we, e_tk, lk_v;
    int          widx, wctr, lk_ctr;
    bit          wv;
    logic [31:0] wtag, wtgt, lk_tag, lk_tgt, e_tgt;

    rst_n = 1'b0; stall_if = 1'b0; modify_pc_ex = 1'b0; update_pc_ex = '0;
    update_btb_ex = 1'b0; pc_ex = '0; ex_branch_taken = 1'b0; jump_addr_ex = '0; ex_is_jump = 1'b0;

    // rst stl mod upc  upd pcex  tk jaddr jmp chk  exp_pc  tk  exp_tgt
    vecs.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0,      0, 0, 0,      0, 0));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 0,      0, 'h4));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 'h4,    0, 'h8));
    vecs.push_back(mk(1, 0, 1, 'h100,  1, 'h100,  1, 'h200,  0, 1, 'h8,    0, 'hC));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 'h100,  1, 'h200));
    vecs.push_back(mk(1, 0, 1, 'h100,  1, 'h100,  0, 0,      0, 1, 'h200,  0, 'h204));
    vecs.push_back(mk(1, 1, 0, 0,      1, 'h100,  0, 0,      0, 1, 'h100,  0, 'h104));
    vecs.push_back(mk(1, 1, 0, 0,      1, 'h100,  0, 0,      0, 1, 'h100,  0, 'h104));
    vecs.push_back(mk(1, 1, 1, 'h80,   1, 'h101,  1, 'h200,  0, 1, 'h100,  0, 'h104));
    vecs.push_back(mk(1, 0, 1, 'h100,  0, 0,      0, 0,      0, 1, 'h80,   0, 'h84));
    vecs.push_back(mk(1, 1, 0, 0,      1, 'h140,  1, 'h300,  0, 1, 'h100,  0, 'h104));
    vecs.push_back(mk(1, 0, 1, 'h140,  0, 0,      0, 0,      0, 1, 'h100,  0, 'h104));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 'h140,  1, 'h300));
    vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0,    0, 1, 'h300,  0, 'h304));
    vecs.push_back(mk(1, 1, 0, 0,      0, 0,      0, 0,      0, 1, 32'hFFFF_FFFC, 0, 'h0));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 32'hFFFF_FFFC, 0, 'h0));
    vecs.push_back(mk(0, 0, 1, 'h500,  1, 'h4,    1, 'h700,  1, 1, 'h0,    0, 'h4));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 'h0,    0, 'h4));
    vecs.push_back(mk(1, 0, 1, 'h100,  0, 0,      0, 0,      0, 1, 'h4,    0, 'h8));
    vecs.push_back(mk(1, 1, 0, 0,      1, 'h100,  1, 'h200,  1, 1, 'h100,  BYP,
                      BYP ? 32'h200 : 32'h104));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 'h100,  1, 'h200));
    vecs.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0,      0, 1, 'h200,  0, 'h204));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d pc_if", i), pc_if, vecs[i].exp_pc);
        check($sformatf("row%0d taken", i), 32'(predictedTaken_if), 32'(vecs[i].exp_tk));
        check($sformatf("row%0d target", i), predicted_target_if, vecs[i].exp_tgt);
      end
    end

    // Random phase: start from a known reset state in both DUT and model.
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(v);
    model_reset();

    for (int n = 0; n < 1500; n++) begin
      v.rst_n  = ($urandom_range(0, 99) != 0);
      v.stall  = ($urandom_range(0, 3) == 0);
      v.modify = ($urandom_range(0, 4) == 0);
      v.upc    = rand_addr();
      v.upd    = ($urandom_range(0, 1) == 1);
      v.pcex   = rand_addr();
      v.taken  = ($urandom_range(0, 1) == 1);
      v.jaddr  = rand_addr();
      v.isjump = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      drive(v);
      #1;

      model_train(v, we, widx, wv, wtag, wtgt, wctr);
      lk_v   = m_valid[idx_of(m_pc)];
      lk_tag = m_tag[idx_of(m_pc)];
      lk_tgt = m_tgt[idx_of(m_pc)];
      lk_ctr = m_ctr[idx_of(m_pc)];
      if (BYP && we && (widx == idx_of(m_pc))) begin
        lk_v = wv; lk_tag = wtag; lk_tgt = wtgt; lk_ctr = wctr;
      end
      e_tk  = lk_v && (lk_tag == (m_pc >> 6)) && (lk_ctr >= 2);
      e_tgt = e_tk ? lk_tgt : m_pc + 32'd4;

      check($sformatf("rnd%0d pc_if", n), pc_if, m_pc);
      check($sformatf("rnd%0d taken", n), 32'(predictedTaken_if), 32'(e_tk));
      check($sformatf("rnd%0d target", n), predicted_target_if, e_tgt);

      if (!v.rst_n) begin
        model_reset();
      end else begin
        if (we) begin
          m_valid[widx] = wv; m_tag[widx] = wtag; m_tgt[widx] = wtgt; m_ctr[widx] = wctr;
        end
        if (v.modify)     m_pc = v.upc;
        else if (!v.stall) m_pc = e_tgt;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
